// File: rtl/pi_mac_alu.sv
// Fixed-point ALU: single-cycle add/sub with optional narrow clamp, iterative
// shift-add multiply, and multiply-accumulate into a private accumulator.
module pi_mac_alu #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 12,
    parameter int unsigned SATW = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] src1,
    input  logic [W-1:0] src0,
    input  logic [1:0]   shift,
    input  logic         saturate,
    input  logic         clr_acc,
    output logic [W-1:0] dst,
    output logic         done,
    output logic         busy,
    output logic         ovf
);

    localparam int unsigned PW = 2 * W - 2;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned W1 = W + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic signed [W-1:0]  SatHi  = W'((2 ** (SATW - 1)) - 1);
    localparam logic signed [W-1:0]  SatLo  = ~SatHi;
    localparam logic signed [PW-1:0] MulHi  = PW'((2 ** (W - 2)) - 1);
    localparam logic signed [PW-1:0] MulLo  = ~MulHi;
    localparam logic signed [W-1:0]  MulHiW = W'((2 ** (W - 2)) - 1);
    localparam logic signed [W-1:0]  MulLoW = ~MulHiW;
    localparam logic signed [W:0]    MacHi  = W1'((2 ** (W - 1)) - 1);
    localparam logic signed [W:0]    MacLo  = ~MacHi;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mac_q, mac_d;
    logic [PW-1:0] prod_q, prod_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [W-2:0]  mplier_q, mplier_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  dst_q, dst_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [W-1:0]         src0s;
    logic signed [W-1:0]  as_sum;
    logic [W-1:0]         as_res;
    logic                 as_ovf;

    logic                 last;
    logic [PW-1:0]        pp;
    logic [PW-1:0]        prod_step;
    logic signed [PW-1:0] prod_sh;
    logic [W-1:0]         mul_res;
    logic                 mul_ovf;
    logic signed [W:0]    mac_sum;
    logic [W-1:0]         mac_res;
    logic                 mac_ovf;

    always_comb begin
        case (shift)
            2'b00:   src0s = src0;
            2'b01:   src0s = {src0[W-2:0], 1'b0};
            default: src0s = {src0[W-3:0], 2'b00};
        endcase
    end

    // Sub is src1 + ~src0s + 1; the clamp acts on the W-bit wrapped sum.
    always_comb begin
        as_sum = $signed(src1 + (op[0] ? ~src0s : src0s) + {{(W - 1){1'b0}}, op[0]});
        as_res = as_sum;
        as_ovf = 1'b0;
        if (saturate && (as_sum > SatHi)) begin
            as_res = SatHi;
            as_ovf = 1'b1;
        end else if (saturate && (as_sum < SatLo)) begin
            as_res = SatLo;
            as_ovf = 1'b1;
        end
    end

    // One partial product per cycle; the multiplier's top bit carries negative weight.
    always_comb begin
        last      = (cnt_q == CW'(W - 2));
        pp        = mplier_q[0] ? mcand_q : '0;
        prod_step = last ? (prod_q - pp) : (prod_q + pp);
        prod_sh   = $signed(prod_step) >>> FRAC;

        mul_res = prod_sh[W-1:0];
        mul_ovf = 1'b0;
        if (prod_sh > MulHi) begin
            mul_res = MulHiW;
            mul_ovf = 1'b1;
        end else if (prod_sh < MulLo) begin
            mul_res = MulLoW;
            mul_ovf = 1'b1;
        end

        mac_sum = $signed({acc_q[W-1], acc_q}) + $signed({mul_res[W-1], mul_res});
        mac_res = mac_sum[W-1:0];
        mac_ovf = 1'b0;
        if (mac_sum > MacHi) begin
            mac_res = MacHi[W-1:0];
            mac_ovf = 1'b1;
        end else if (mac_sum < MacLo) begin
            mac_res = MacLo[W-1:0];
            mac_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mac_d    = mac_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        dst_d    = dst_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (!op[1]) begin
                        dst_d   = as_res;
                        ovf_d   = as_ovf;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d  = StMul;
                        cnt_d    = '0;
                        mac_d    = op[0];
                        prod_d   = '0;
                        mcand_d  = {{(W - 1){src1[W-2]}}, src1[W-2:0]};
                        mplier_d = src0s[W-2:0];
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (mac_q) begin
                        dst_d = mac_res;
                        ovf_d = mul_ovf | mac_ovf;
                        acc_d = mac_res;
                    end else begin
                        dst_d = mul_res;
                        ovf_d = mul_ovf;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear beats a coincident MAC write-back.
        if (clr_acc) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mac_q    <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            dst_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mac_q    <= mac_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            dst_q    <= dst_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign dst  = dst_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = (state_q == StMul);

endmodule

// File: tb/tb_pi_mac_alu.sv
// Self-checking bench for pi_mac_alu (W=16, FRAC=12, SATW=12) against an
// arithmetic reference model.
module tb_pi_mac_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] src1;
    logic [15:0] src0;
    logic [1:0]  shift;
    logic        saturate;
    logic        clr_acc;
    logic [15:0] dst;
    logic        done;
    logic        busy;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int acc_m  = 0;

    always #5 clk = ~clk;

    pi_mac_alu #(
        .W    (16),
        .FRAC (12),
        .SATW (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src0     (src0),
        .shift    (shift),
        .saturate (saturate),
        .clr_acc  (clr_acc),
        .dst      (dst),
        .done     (done),
        .busy     (busy),
        .ovf      (ovf)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] shifted(input logic [15:0] v, input logic [1:0] sh);
        int m;
        int t;
        m = (sh == 2'b00) ? 1 : ((sh == 2'b01) ? 2 : 4);
        t = int'(v) * m;
        return t[15:0];
    endfunction

    function automatic void ref_addsub(input logic [1:0] o, input logic [15:0] a,
                                       input logic [15:0] bs, input logic sat,
                                       output logic [15:0] r, output logic ov);
        int s;
        logic [15:0] w;
        s = o[0] ? (int'($signed(a)) - int'($signed(bs))) : (int'($signed(a)) + int'($signed(bs)));
        w = s[15:0];
        s = int'($signed(w));
        ov = 1'b0;
        if (sat && s > 2047) begin
            s = 2047; ov = 1'b1;
        end else if (sat && s < -2048) begin
            s = -2048; ov = 1'b1;
        end
        r = s[15:0];
    endfunction

    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] bs,
                                    output int r, output logic ov);
        longint x, y, p;
        x = longint'(a[14:0]);
        if (a[14]) x -= 32768;
        y = longint'(bs[14:0]);
        if (bs[14]) y -= 32768;
        p = (x * y) >>> 12;
        ov = 1'b0;
        if (p > 16383) begin
            p = 16383; ov = 1'b1;
        end else if (p < -16384) begin
            p = -16384; ov = 1'b1;
        end
        r = int'(p);
    endfunction

    function automatic void ref_mac(input int mr, output int r, output logic ov);
        int s;
        s = acc_m + mr;
        ov = 1'b0;
        if (s > 32767) begin
            s = 32767; ov = 1'b1;
        end else if (s < -32768) begin
            s = -32768; ov = 1'b1;
        end
        r = s;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge with the DUT accepting; returns one cycle after accept.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] sh, input logic sat, input logic clr);
        op = o; src1 = a; src0 = b; shift = sh; saturate = sat; clr_acc = clr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; clr_acc = 1'b0;
        op = 2'($urandom); src1 = 16'($urandom); src0 = 16'($urandom);
        shift = 2'($urandom); saturate = 1'($urandom);
    endtask

    // lat counts cycles after accept until done (41 means it never came).
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (done !== 1'b1 && lat <= 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 2'b00; src1 = 16'h0100; src0 = 16'h0100;
        shift = 2'b00; saturate = 1'b0; clr_acc = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dst !== 16'h0000) begin n_fail++; $display("FAIL reset_dst got %h want 0000", dst); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || dst !== 16'h0000) begin
            n_fail++; $display("FAIL start_with_rst done=%b dst=%h want 0/0000", done, dst);
        end
        acc_m = 0;
    endtask

    task automatic test_addsub();
        issue(2'b00, 16'h0700, 16'h0200, 2'b00, 1'b1, 1'b0);
        n_cmp++; if (done !== 1'b1 || dst !== 16'h07FF || ovf !== 1'b1) begin
            n_fail++; $display("FAIL add_sat done=%b dst=%h ovf=%b want 1/07FF/1", done, dst, ovf);
        end
        issue(2'b00, 16'h0700, 16'h0200, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (done !== 1'b1 || dst !== 16'h0900 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL add_wrap done=%b dst=%h ovf=%b want 1/0900/0", done, dst, ovf);
        end
        issue(2'b00, 16'hF000, 16'h0100, 2'b01, 1'b1, 1'b0);
        n_cmp++; if (dst !== 16'hF800 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL add_sat_neg dst=%h ovf=%b want F800/1", dst, ovf);
        end
        issue(2'b01, 16'h0010, 16'h0004, 2'b10, 1'b0, 1'b0);
        n_cmp++; if (done !== 1'b1 || dst !== 16'h0000 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL sub_shift done=%b dst=%h ovf=%b want 1/0000/0", done, dst, ovf);
        end
        issue(2'b00, 16'h0123, 16'h0011, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (done !== 1'b1 || dst !== 16'h0134) begin
            n_fail++; $display("FAIL add_from_done done=%b dst=%h want 1/0134", done, dst);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (done !== 1'b0 || dst !== 16'h0134 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL hold done=%b dst=%h ovf=%b want 0/0134/0", done, dst, ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        logic        eo;
        for (int k = 0; k < 5; k++) begin
            op = {1'b0, 1'($urandom)}; src1 = 16'($urandom); src0 = 16'($urandom);
            shift = 2'($urandom); saturate = 1'b0; start = 1'b1;
            ref_addsub(op, src1, shifted(src0, shift), 1'b0, e, eo);
            @(negedge clk);
            n_cmp++; if (done !== 1'b1 || dst !== e || ovf !== eo) begin
                n_fail++; $display("FAIL b2b[%0d] done=%b dst=%h ovf=%b want 1/%h/%b", k, done, dst, ovf, e, eo);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat, bc;
        issue(2'b10, 16'h1000, 16'h0800, 2'b00, 1'b0, 1'b0);
        wait_done(lat, bc);
        n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL mul_latency got %0d want 16", lat); end
        n_cmp++; if (bc != 15) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want 15", bc); end
        n_cmp++; if (dst !== 16'h0800 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL mul_basic dst=%h ovf=%b want 0800/0", dst, ovf);
        end
        issue(2'b10, 16'h7000, 16'h3000, 2'b00, 1'b0, 1'b0);
        wait_done(lat, bc);
        n_cmp++; if (lat != 16 || dst !== 16'hD000 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL mul_neg lat=%0d dst=%h ovf=%b want 16/D000/0", lat, dst, ovf);
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || dst !== 16'hD000) begin
            n_fail++; $display("FAIL mul_pulse done=%b busy=%b dst=%h want 0/0/D000", done, busy, dst);
        end
    endtask

    task automatic test_mul_ignore_start();
        int nd, dc;
        logic [15:0] d;
        logic        o;
        nd = 0; dc = 0; d = '0; o = 1'b0;
        issue(2'b10, 16'h3000, 16'h3000, 2'b00, 1'b0, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                nd++; dc = c; d = dst; o = ovf;
            end
            op = 2'b00;
            start = (c >= 2 && c <= 8 && (c % 2) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++; if (nd != 1 || dc != 16) begin
            n_fail++; $display("FAIL mul_start_ignored dones=%0d at=%0d want 1 at 16", nd, dc);
        end
        n_cmp++; if (d !== 16'h3FFF || o !== 1'b1) begin
            n_fail++; $display("FAIL mul_clamp dst=%h ovf=%b want 3FFF/1", d, o);
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e;
        logic        eo;
    } row_t;

    task automatic test_mac();
        int lat, bc;
        row_t rows[7];
        rows[0] = '{2'b11, 16'h1000, 16'h1000, 16'h1000, 1'b0};
        rows[1] = '{2'b10, 16'h2000, 16'h1000, 16'h2000, 1'b0};
        rows[2] = '{2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0};
        rows[3] = '{2'b11, 16'h1000, 16'h1000, 16'h2000, 1'b0};
        rows[4] = '{2'b11, 16'h3000, 16'h3000, 16'h5FFF, 1'b1};
        rows[5] = '{2'b11, 16'h3000, 16'h3000, 16'h7FFF, 1'b1};
        rows[6] = '{2'b11, 16'h7000, 16'h1000, 16'h6FFF, 1'b0};
        clr_acc = 1'b1;
        @(negedge clk);
        clr_acc = 1'b0;
        issue(2'b11, 16'h1000, 16'h1000, 2'b00, 1'b0, 1'b0);
        wait_done(lat, bc);
        n_cmp++; if (lat != 16 || dst !== 16'h1000 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL mac_first lat=%0d dst=%h ovf=%b want 16/1000/0", lat, dst, ovf);
        end
        issue(2'b11, 16'h1000, 16'h1000, 2'b00, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        clr_acc = 1'b1;
        @(negedge clk);
        clr_acc = 1'b0;
        n_cmp++; if (done !== 1'b1 || dst !== 16'h2000) begin
            n_fail++; $display("FAIL mac_clr_coincident done=%b dst=%h want 1/2000", done, dst);
        end
        for (int i = 0; i < 7; i++) begin
            issue(rows[i].o, rows[i].a, rows[i].b, 2'b00, 1'b0, 1'b0);
            wait_done(lat, bc);
            n_cmp++; if (dst !== rows[i].e || ovf !== rows[i].eo) begin
                n_fail++; $display("FAIL mac_row[%0d] dst=%h ovf=%b want %h/%b", i, dst, ovf, rows[i].e, rows[i].eo);
            end
        end
        clr_acc = 1'b1;
        @(negedge clk);
        clr_acc = 1'b0;
        acc_m = 0;
    endtask

    task automatic test_random();
        logic [1:0]  o, sh;
        logic [15:0] a, b, bs, e;
        logic [12:0] t;
        logic        sat, clr, eo, mo, so;
        int          mr, sr, lat, bc, exp_lat;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
            sh = 2'($urandom); sat = 1'($urandom); clr = ($urandom_range(0, 7) == 0);
            if ((!o[1] && sat) || (o[1] && $urandom_range(0, 1) == 1)) begin
                t = 13'($urandom); a = {{3{t[12]}}, t};
                t = 13'($urandom); b = {{3{t[12]}}, t};
                sh = 2'($urandom_range(0, 1));
            end
            if (clr) acc_m = 0;
            bs = shifted(b, sh);
            if (!o[1]) begin
                ref_addsub(o, a, bs, sat, e, eo);
                exp_lat = 1;
            end else begin
                ref_mul(a, bs, mr, mo);
                if (o[0]) begin
                    ref_mac(mr, sr, so);
                    acc_m = sr;
                    e = sr[15:0];
                    eo = mo | so;
                end else begin
                    e = mr[15:0];
                    eo = mo;
                end
                exp_lat = 16;
            end
            issue(o, a, b, sh, sat, clr);
            wait_done(lat, bc);
            n_cmp++; if (lat != exp_lat || dst !== e || ovf !== eo) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%b a=%h b=%h sh=%b sat=%b lat=%0d dst=%h ovf=%b want %0d/%h/%b",
                         i, o, a, b, sh, sat, lat, dst, ovf, exp_lat, e, eo);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat, bc, nd;
        issue(2'b11, 16'h3000, 16'h3000, 2'b00, 1'b0, 1'b1);
        wait_done(lat, bc);
        n_cmp++; if (dst !== 16'h3FFF || ovf !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_mac dst=%h ovf=%b want 3FFF/1", dst, ovf);
        end
        issue(2'b10, 16'h1000, 16'h0800, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_mul_busy got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dst !== 16'h0000 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL mid_mul_reset busy=%b done=%b dst=%h ovf=%b want 0/0/0000/0", busy, done, dst, ovf);
        end
        nd = 0;
        repeat (25) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        n_cmp++; if (nd != 0) begin n_fail++; $display("FAIL no_done_after_reset dones=%0d want 0", nd); end
        acc_m = 0;
        issue(2'b11, 16'h1000, 16'h1000, 2'b00, 1'b0, 1'b0);
        wait_done(lat, bc);
        n_cmp++; if (dst !== 16'h1000) begin n_fail++; $display("FAIL acc_after_reset dst=%h want 1000", dst); end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_back_to_back();
        test_mul();
        test_mul_ignore_start();
        test_mac();
        test_random();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
